// File: rtl/mul_pkg.sv
// Shared constants and state encoding for the iterative shift-add multiplier.
package mul_pkg;

  localparam int WIDTH = 32;
  localparam int STEPS = 32;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_add_if.sv
// Operand and result valid/ready handshake bundle for mul_shift_add.
interface mul_shift_add_if;
  import mul_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   prod;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, prod
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, prod
  );

endinterface

// File: rtl/mul_shift_add_adder.sv
// The shared ToyALU 32-bit ripple adder; the multiplier's only arithmetic resource.
module adder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'h0000_0000, cin};

endmodule

// File: rtl/mul_shift_add.sv
// Iterative unsigned WIDTHxWIDTH multiplier: one add and one right shift per cycle
// through the external 32-bit adder, with valid/ready on operands and result.
module mul_shift_add #(
  parameter int WIDTH = mul_pkg::WIDTH,
  parameter int STEPS = mul_pkg::STEPS
) (
  input  logic           clk,
  input  logic           rst,
  mul_shift_add_if.slave bus
);
  import mul_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_p;
  logic [CNT_W-1:0]     r_cnt;
  logic [WIDTH-1:0]     w_addend;
  logic [WIDTH-1:0]     w_sum;
  logic                 w_cout;

  assign w_addend = r_p[0] ? r_mcand : {WIDTH{1'b0}};

  adder_32bit u_adder (
    .a    (r_p[2*WIDTH-1:WIDTH]),
    .b    (w_addend),
    .cin  (1'b0),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // Next-state decode; the last step (cnt at STEPS-1) still executes before DONE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid) w_state_nxt = S_BUSY;
        else              w_state_nxt = S_IDLE;
      end
      S_BUSY: begin
        if (r_cnt == CNT_W'(STEPS - 1)) w_state_nxt = S_DONE;
        else                            w_state_nxt = S_BUSY;
      end
      S_DONE: begin
        if (bus.out_ready) w_state_nxt = S_IDLE;
        else               w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers; the carry re-enters P as its top bit on each shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mcand <= {WIDTH{1'b0}};
      r_p     <= {(2*WIDTH){1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_mcand <= bus.a;
            r_p     <= {{WIDTH{1'b0}}, bus.b};
            r_cnt   <= {CNT_W{1'b0}};
          end
        end
        S_BUSY: begin
          r_p   <= {w_cout, w_sum, r_p[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
        end
        S_DONE:  r_p <= r_p;
        default: r_p <= r_p;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == S_IDLE);
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.prod      = r_p;

endmodule

// File: tb/tb_mul_shift_add.sv
// Scoreboard bench for mul_shift_add: expected products are queued on accept and
// compared, along with latency and handshake behaviour, when the result appears.
module tb_mul_shift_add;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;
  logic [63:0] sb_q[$];

  mul_shift_add_if bus ();

  mul_shift_add u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, presents one operand pair for the accept edge, queues the product.
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) check_val("send_timeout", 64'(bus.in_ready), 64'd1);
    bus.a        = a;
    bus.b        = b;
    bus.in_valid = 1'b1;
    sb_q.push_back(64'(a) * 64'(b));
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Called right after the accept edge: checks 32-cycle latency, holds backpressure,
  // then hands the result off and checks the return to IDLE.
  task automatic recv(input int hold, input string tag);
    int n = 0;
    logic [63:0] exp;
    while (bus.out_valid !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    check_val({tag, "_lat"}, 64'(n), 64'd32);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    check_val({tag, "_prod"}, bus.prod, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val({tag, "_hold_prod"}, bus.prod, exp);
      check_val({tag, "_hold_ov"}, 64'(bus.out_valid), 64'd1);
      check_val({tag, "_hold_ir"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_val({tag, "_idle_ir"}, 64'(bus.in_ready), 64'd1);
    check_val({tag, "_idle_ov"}, 64'(bus.out_valid), 64'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = 32'h0;
    bus.b         = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    check_val("rst_ir", 64'(bus.in_ready), 64'd1);
    check_val("rst_ov", 64'(bus.out_valid), 64'd0);
    check_val("rst_prod", bus.prod, 64'h0);

    send(32'd3, 32'd5);
    recv(0, "basic");
    check_val("basic_const", 64'(32'd3) * 64'(32'd5), 64'h0F);

    send(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    recv(0, "carry");

    send(32'h1234_5678, 32'h9ABC_DEF0);
    recv(10, "bp");

    // Second pair held on in_valid throughout the first multiply.
    send(32'h0000_00AB, 32'h0000_0CDE);
    bus.a        = 32'h0001_0001;
    bus.b        = 32'h0000_FFFF;
    bus.in_valid = 1'b1;
    recv(0, "ign1");
    sb_q.push_back(64'h0000_0000_FFFF_FFFF);
    tick();
    bus.in_valid = 1'b0;
    check_val("ign2_busy_ir", 64'(bus.in_ready), 64'd0);
    recv(0, "ign2");

    // Reset arrives at the edge of step 17; the pending product is discarded.
    send(32'd7, 32'd9);
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb_q.pop_back());
    check_val("mid_rst_ir", 64'(bus.in_ready), 64'd1);
    check_val("mid_rst_ov", 64'(bus.out_valid), 64'd0);
    check_val("mid_rst_prod", bus.prod, 64'h0);
    send(32'd7, 32'd9);
    recv(0, "rerun");

    send(32'hDEAD_BEEF, 32'h0);
    recv(0, "zero_b");
    send(32'h0, 32'hCAFE_F00D);
    recv(0, "zero_a");

    for (int k = 0; k < 4; k++) begin
      send($urandom, $urandom);
      recv(k, "rand");
    end

    check_val("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_shift_add.md
# mul_shift_add

Iterative unsigned 32×32→64 multiplier for the ToyALU datapath. It sits directly upstream of the 32-bit adder and reuses it as its only arithmetic resource, driving one add per cycle and consuming the sum and carry back into its product register. Operands enter and results leave over valid/ready handshakes, so the block can hang off the ALU operand and result paths without extra glue.

## Interface
Parameters:
- WIDTH, 32: operand width. Fixed by the 32-bit adder; other values are unsupported.
- STEPS, 32: add/shift iterations per multiply; always equal to WIDTH.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  32  multiplicand (unsigned).
- b  in  32  multiplier (unsigned).
- out_valid  out  1  product present; high only in DONE.
- out_ready  in  1  consumer takes the product.
- prod  out  64  product a×b; valid while out_valid is high.

## Operation
- States: IDLE → BUSY → DONE → IDLE. Use a 2-bit encoding.
- Registers:
  - mcand[31:0]
  - P[63:0] (P_hi = P[63:32], P_lo = P[31:0])
  - cnt[5:0]
- IDLE:
  - in_ready=1.
  - On in_valid: mcand←a, P←{32'h0, b}, cnt←0, go BUSY.
- BUSY, one step per cycle:
  - Adder inputs: P_hi and (P[0] ? mcand : 0), cin=0.
  - Result: sum[31:0], cout.
  - Update P←{cout, sum, P_lo[31:1]}. This is a 65-bit value shifted right by one, keeping 64 bits.
  - cnt←cnt+1.
  - When cnt==31 at the edge, the step still executes and the state moves to DONE.
- DONE:
  - out_valid=1, prod=P.
  - Hold prod and out_valid stable until out_ready is seen.
  - On out_valid&&out_ready, go IDLE.
- in_valid outside IDLE is ignored; operands are not latched.
- out_ready outside DONE is ignored.
- The carry out of every step is kept in P. No overflow is possible, because the product always fits in 64 bits.
- Outputs are registered or decoded from the state register only. There is no combinational path from in_valid to out_valid, or from out_ready to in_ready.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, prod=64'h0. Also P=0, mcand=0, cnt=0.
- Reset mid-operation (BUSY or DONE): abort at that edge and return to IDLE with all values above. A pending product is discarded.
- Latency:
  - Accept edge E0. BUSY steps occur at edges E1..E32.
  - out_valid is high from the cycle after E32, so the result is visible 32 cycles after acceptance.
- The result handshake edge returns the block to IDLE; in_ready is high in the next cycle.
- Minimum initiation interval: 34 cycles. There is no overlap of a new accept with the DONE handshake.
- Backpressure: DONE persists indefinitely while out_ready=0.
- Operand edge cases:
  - b=0: all steps add 0, prod=0, latency unchanged.
  - a=0: same behaviour.
  - There is no early termination.
- The adder path is purely combinational within one cycle: P_hi → adder → P.

## Structure
- Shared package (mul_pkg): WIDTH, STEPS, CNT_W=6, and state constants S_IDLE=0, S_BUSY=1, S_DONE=2.
- Sub-module: instantiate the existing 32-bit adder (adder_32bit) for the per-step add.
  - Do not write an inline `+`; the block exists to exercise that adder.
- Keep all control and datapath in one module body. The expected size is about 150 RTL lines.

## Test plan
- Basic product: a=3, b=5, in_valid pulse.
  - Required: out_valid rises exactly 32 cycles after accept, prod=64'h0F.
- Carry path: a=b=32'hFFFF_FFFF.
  - Required: prod=64'hFFFF_FFFE_0000_0001.
  - Confirms that a step producing cout=1 keeps that carry in P.
- Backpressure: a=32'h1234_5678, b=32'h9ABC_DEF0, out_ready=0 for 10 cycles after out_valid.
  - Required: prod=64'h0B00_EA4E_242D_2080 held stable all 10 cycles.
  - Required: in_ready=0 throughout, then IDLE one cycle after out_ready=1.
- Ignored input: in_valid held high with new operands during BUSY.
  - Required: first result unaffected; second pair accepted only once in_ready returns.
- Reset mid-run: assert rst at step 17 of a=7, b=9.
  - Required next cycle: in_ready=1, out_valid=0, prod=0.
  - A new a=7, b=9 then yields prod=63 after 32 cycles.
- Zero operand: a=32'hDEAD_BEEF, b=0.
  - Required: prod=0 with the full 32-cycle latency.
